key_action_shaper: RTL and testbench

KEY_ACTION_SHAPER -- requirements
Module: key_action_shaper

---
 rtl/key_action_shaper.sv | 141 ++++++++++++++
 tb/tb_key_action_shaper.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/key_action_shaper.sv
// Key action shaper: synchronizes raw key levels, derives move/rotate requests with
// DAS/ARR auto-repeat and emits at most one registered action pulse per cycle.
module key_action_shaper #(
   parameter int unsigned DAS_CYC  = 4000000,
   parameter int unsigned ARR_CYC  = 1250000,
   parameter int unsigned DOWN_CYC = 1250000,
   parameter int unsigned CNT_W    = 24
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic k_left,
   input  logic k_right,
   input  logic k_down,
   input  logic k_spin,
   input  logic k_drop,
   input  logic k_hold,
   output logic a_left,
   output logic a_right,
   output logic a_down,
   output logic a_spin,
   output logic a_drop,
   output logic a_hold,
   output logic pend
);

   typedef enum logic [1:0] {StIdle, StDelay, StRepeat} lr_st_e;

   localparam logic [CNT_W-1:0] DAS_LAST  = CNT_W'(DAS_CYC - 1);
   localparam logic [CNT_W-1:0] ARR_LAST  = CNT_W'(ARR_CYC - 1);
   localparam logic [CNT_W-1:0] DOWN_LAST = CNT_W'(DOWN_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   // Bit order is also the priority order: index 0 (drop) wins.
   logic [5:0] k_raw, sync_q, s_q, g, g_prev_q;
   logic [5:0] req, avail, pick, pnd_q, act_q;
   logic [2:0] edge_req_q;
   logic [1:0] g_lr, lr_req_q;
   logic       lr_block, dn_req_q, pend_q;
   lr_st_e     lr_st_q [2];
   logic [CNT_W-1:0] lr_cnt_q [2];
   logic [CNT_W-1:0] dn_cnt_q;

   assign k_raw    = {k_down, k_right, k_left, k_spin, k_hold, k_drop};
   assign g        = s_q & {6{en}};
   assign g_lr     = g[4:3];
   assign lr_block = g[3] & g[4];

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q     <= '0;
         s_q        <= '0;
         g_prev_q   <= '0;
         edge_req_q <= '0;
      end else begin
         sync_q     <= k_raw;
         s_q        <= sync_q;
         g_prev_q   <= g;
         edge_req_q <= g[2:0] & ~g_prev_q[2:0];
      end
   end

   // Left/right DAS-ARR machines; opposing keys held together park both in idle.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         lr_req_q[i] <= 1'b0;
         if (rst || !g_lr[i] || lr_block) begin
            lr_st_q[i]  <= StIdle;
            lr_cnt_q[i] <= '0;
         end else begin
            case (lr_st_q[i])
               StIdle: begin
                  lr_req_q[i] <= 1'b1;
                  lr_cnt_q[i] <= '0;
                  lr_st_q[i]  <= StDelay;
               end
               StDelay: begin
                  if (lr_cnt_q[i] == DAS_LAST) begin
                     lr_req_q[i] <= 1'b1;
                     lr_cnt_q[i] <= '0;
                     lr_st_q[i]  <= StRepeat;
                  end else begin
                     lr_cnt_q[i] <= lr_cnt_q[i] + CNT_ONE;
                  end
               end
               StRepeat: begin
                  if (lr_cnt_q[i] == ARR_LAST) begin
                     lr_req_q[i] <= 1'b1;
                     lr_cnt_q[i] <= '0;
                  end else begin
                     lr_cnt_q[i] <= lr_cnt_q[i] + CNT_ONE;
                  end
               end
               default: begin
                  lr_st_q[i]  <= StIdle;
                  lr_cnt_q[i] <= '0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || !g[5]) begin
         dn_cnt_q <= '0;
         dn_req_q <= 1'b0;
      end else if (!g_prev_q[5] || dn_cnt_q == DOWN_LAST) begin
         dn_cnt_q <= '0;
         dn_req_q <= 1'b1;
      end else begin
         dn_cnt_q <= dn_cnt_q + CNT_ONE;
         dn_req_q <= 1'b0;
      end
   end

   // Requests merge into pending bits; the lowest set bit is emitted.
   assign req   = {dn_req_q, lr_req_q, edge_req_q};
   assign avail = pnd_q | req;
   assign pick  = avail & (~avail + 6'd1);

   always_ff @(posedge clk) begin
      if (rst || !en) begin
         pnd_q  <= '0;
         act_q  <= '0;
         pend_q <= 1'b0;
      end else begin
         pnd_q  <= avail & ~pick;
         act_q  <= pick;
         pend_q <= |(avail & ~pick);
      end
   end

   assign a_drop  = act_q[0];
   assign a_hold  = act_q[1];
   assign a_spin  = act_q[2];
   assign a_left  = act_q[3];
   assign a_right = act_q[4];
   assign a_down  = act_q[5];
   assign pend    = pend_q;

endmodule

// File: tb/tb_key_action_shaper.sv
// Bench for key_action_shaper: run-length reference model checked every cycle, directed
// scenarios with literal pulse times, then randomized key/enable/reset traffic.
module tb_key_action_shaper;

   localparam int DAS  = 10;
   localparam int ARR  = 4;
   localparam int DOWN = 3;

   logic clk = 1'b0;
   logic rst, en;
   logic k_left, k_right, k_down, k_spin, k_drop, k_hold;
   logic a_left, a_right, a_down, a_spin, a_drop, a_hold, pend;
   logic [5:0] act_vec;

   int total = 0;
   int bad = 0;
   bit chk_on = 1'b0;

   always #5 clk = ~clk;

   key_action_shaper #(
      .DAS_CYC (DAS),
      .ARR_CYC (ARR),
      .DOWN_CYC(DOWN),
      .CNT_W   (8)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .k_left (k_left),
      .k_right(k_right),
      .k_down (k_down),
      .k_spin (k_spin),
      .k_drop (k_drop),
      .k_hold (k_hold),
      .a_left (a_left),
      .a_right(a_right),
      .a_down (a_down),
      .a_spin (a_spin),
      .a_drop (a_drop),
      .a_hold (a_hold),
      .pend   (pend)
   );

   assign act_vec = {a_down, a_right, a_left, a_spin, a_hold, a_drop};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
      end
   endtask

   // Request rule from how long a key has been effectively held (r = edges held, 1 = first).
   function automatic bit req_rule(input int idx, input int r);
      if (r == 0) return 1'b0;
      if (idx <= 2) return r == 1;
      if (idx == 5) return ((r - 1) % DOWN) == 0;
      if (r == 1) return 1'b1;
      if (r - 1 < DAS) return 1'b0;
      return ((r - 1 - DAS) % ARR) == 0;
   endfunction

   // Reference model, index order drop,hold,spin,left,right,down = priority order.
   int run [6];
   bit [5:0] m_s1, m_s, m_req, m_pnd, exp_act;
   bit exp_pend;

   always @(posedge clk) begin
      bit [5:0] kin, gm, nreq, avail, pick;
      bit active, found;
      kin = {k_down, k_right, k_left, k_spin, k_hold, k_drop};
      if (rst) begin
         for (int i = 0; i < 6; i++) run[i] = 0;
         m_s1 = '0; m_s = '0; m_req = '0; m_pnd = '0; exp_act = '0; exp_pend = 1'b0;
      end else begin
         gm = en ? m_s : 6'b0;
         for (int i = 0; i < 6; i++) begin
            active = gm[i];
            if (i == 3 || i == 4) active = active && !(gm[3] && gm[4]);
            run[i] = active ? run[i] + 1 : 0;
            nreq[i] = req_rule(i, run[i]);
         end
         if (!en) begin
            exp_act = '0; m_pnd = '0; exp_pend = 1'b0;
         end else begin
            avail = m_pnd | m_req;
            pick = '0;
            found = 1'b0;
            for (int i = 0; i < 6; i++) begin
               if (avail[i] && !found) begin
                  pick[i] = 1'b1;
                  found = 1'b1;
               end
            end
            exp_act = pick;
            m_pnd = avail & ~pick;
            exp_pend = |m_pnd;
         end
         m_req = nreq;
         m_s = m_s1;
         m_s1 = kin;
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         check("model_act", act_vec, exp_act);
         check("model_pend", pend, exp_pend);
      end
   end

   task automatic idle(input int n);
      k_left = 0; k_right = 0; k_down = 0; k_spin = 0; k_drop = 0; k_hold = 0;
      en = 1'b1;
      rst = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; en = 1'b0;
      k_left = 0; k_right = 0; k_down = 0; k_spin = 0; k_drop = 0; k_hold = 0;
      repeat (2) @(negedge clk);
      chk_on = 1'b1;
      check("reset_act", act_vec, 0);
      check("reset_pend", pend, 0);
      idle(8);

      // Spin held: one pulse, no repeat.
      k_spin = 1;
      for (int i = 1; i <= 24; i++) begin
         @(negedge clk);
         check("spin_pulse", a_spin, (i == 4));
         if (i == 20) k_spin = 0;
      end
      idle(8);

      // Left held: first pulse, DAS, then ARR repeats.
      k_left = 1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         check("left_repeat", a_left, (i inside {4, 14, 18, 22, 26}));
         if (i == 24) k_left = 0;
      end
      idle(8);

      // Right pressed while left held parks both; left restarts after release.
      k_left = 1;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         check("lr_left", a_left, (i inside {4, 19, 29}));
         check("lr_right", a_right, 0);
         if (i == 5) k_right = 1;
         if (i == 15) k_right = 0;
      end
      idle(12);

      // Simultaneous drop/hold/spin: priority serialization.
      k_drop = 1; k_hold = 1; k_spin = 1;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         check("burst_drop", a_drop, (i == 4));
         check("burst_hold", a_hold, (i == 5));
         check("burst_spin", a_spin, (i == 6));
         check("burst_pend", pend, (i inside {4, 5}));
      end
      idle(8);

      // Down repeat, cut by en low, fresh press when en returns.
      k_down = 1;
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         check("down_en", a_down, (i inside {4, 7, 14}));
         if (i == 10) check("down_en_pend", pend, 0);
         if (i == 8) en = 1'b0;
         if (i == 12) en = 1'b1;
      end
      idle(10);

      // Reset mid-repeat, key still held afterwards.
      k_left = 1;
      for (int i = 1; i <= 36; i++) begin
         @(negedge clk);
         check("rst_left", a_left, (i inside {4, 14, 18, 25, 35}));
         if (i == 21) begin
            check("rst_act", act_vec, 0);
            check("rst_pend", pend, 0);
            rst = 1'b0;
         end
         if (i == 20) rst = 1'b1;
      end
      idle(10);

      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         if ($urandom_range(0, 19) == 0) k_left = ~k_left;
         if ($urandom_range(0, 19) == 0) k_right = ~k_right;
         if ($urandom_range(0, 19) == 0) k_down = ~k_down;
         if ($urandom_range(0, 19) == 0) k_spin = ~k_spin;
         if ($urandom_range(0, 19) == 0) k_drop = ~k_drop;
         if ($urandom_range(0, 19) == 0) k_hold = ~k_hold;
         if ($urandom_range(0, 99) == 0) en = ~en;
         rst = ($urandom_range(0, 399) == 0);
      end
      idle(20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
